// File: rtl/frogg_input_ctrl_pkg.sv
// Shared constants, button indices and repeat-FSM state type for the Frogg input front end.
package frogg_input_ctrl_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_LT    = 2;
  localparam int BTN_RT    = 3;
  localparam int BTN_START = 4;
  localparam int BTN_COUNT = 5;
  localparam int DIR_COUNT = 4;

  // Default timing at 25 MHz
  localparam int DEF_DEBOUNCE_LIMIT = 250000;
  localparam int DEF_REPEAT_DELAY   = 6250000;
  localparam int DEF_REPEAT_PERIOD  = 2500000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to hold 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/frogg_input_ctrl_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw switch.
module frogg_debounce
  import frogg_input_ctrl_pkg::*;
#(
  parameter int c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level
);

  localparam int CW = cnt_width(c_DEBOUNCE_LIMIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(c_DEBOUNCE_LIMIT - 1);

  logic          sync_0;
  logic          sync_1;
  logic [CW-1:0] cnt;

  // Synchronise, then flip the level only after LIMIT consecutive differing clocks
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      cnt     <= '0;
      o_Level <= 1'b0;
    end else begin
      sync_0 <= i_Raw;
      sync_1 <= sync_0;
      if (sync_1 == o_Level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_Level <= sync_1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frogg_input_ctrl.sv
// Frogg button front end: debounced levels, gated step pulses with hold-to-repeat, start pulse.
module frogg_input_ctrl
  import frogg_input_ctrl_pkg::*;
#(
  parameter int c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int c_REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int c_REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic [4:0] i_Btn_Raw,
  output logic [4:0] o_Btn_Level,
  output logic       o_Step_Up,
  output logic       o_Step_Dn,
  output logic       o_Step_Lt,
  output logic       o_Step_Rt,
  output logic       o_Start_Pulse
);

  localparam int DLIM    = (c_REPEAT_DELAY > 0) ? c_REPEAT_DELAY - 1 : 0;
  localparam int PLIM    = (c_REPEAT_PERIOD > 0) ? c_REPEAT_PERIOD - 1 : 0;
  localparam int CNT_MAX = (DLIM > PLIM) ? DLIM : PLIM;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DLIM);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PLIM);
  localparam rep_state_t AFTER_FIRST = (c_REPEAT_DELAY == 0) ? S_IDLE : S_DELAY;

  logic [BTN_COUNT-1:0] lvl;
  logic [BTN_COUNT-1:0] lvl_d;
  logic [BTN_COUNT-1:0] rise;
  logic [DIR_COUNT-1:0] allowed;
  logic [DIR_COUNT-1:0] step_q;
  logic                 start_q;

  for (genvar b = 0; b < BTN_COUNT; b++) begin : g_deb
    frogg_debounce #(
      .c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)
    ) u_deb (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Raw  (i_Btn_Raw[b]),
      .o_Level(lvl[b])
    );
  end

  assign rise = lvl & ~lvl_d;

  // Step gating: enable plus opposite-direction conflict blocking
  always_comb begin
    allowed = {DIR_COUNT{i_Enable}};
    if (lvl[BTN_UP] && lvl[BTN_DN]) begin
      allowed[BTN_UP] = 1'b0;
      allowed[BTN_DN] = 1'b0;
    end
    if (lvl[BTN_LT] && lvl[BTN_RT]) begin
      allowed[BTN_LT] = 1'b0;
      allowed[BTN_RT] = 1'b0;
    end
  end

  // Edge-detect history and the start pulse, which ignores enable
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lvl_d   <= '0;
      start_q <= 1'b0;
    end else begin
      lvl_d   <= lvl;
      start_q <= rise[BTN_START];
    end
  end

  for (genvar g = 0; g < DIR_COUNT; g++) begin : g_dir
    rep_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             step;

    // Repeat FSM; a blocked direction drops straight back to IDLE, so a
    // press that began while blocked needs a fresh rising edge
    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        state <= S_IDLE;
        cnt   <= '0;
        step  <= 1'b0;
      end else begin
        step <= 1'b0;
        if (!allowed[g]) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              cnt <= '0;
              if (rise[g]) begin
                step  <= 1'b1;
                state <= AFTER_FIRST;
              end
            end
            S_DELAY: begin
              if (!lvl[g]) begin
                state <= S_IDLE;
                cnt   <= '0;
              end else if (cnt == DELAY_LAST) begin
                step  <= 1'b1;
                cnt   <= '0;
                state <= S_REPEAT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            S_REPEAT: begin
              if (!lvl[g]) begin
                state <= S_IDLE;
                cnt   <= '0;
              end else if (cnt == PERIOD_LAST) begin
                step <= 1'b1;
                cnt  <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign step_q[g] = step;
  end

  assign o_Btn_Level   = lvl;
  assign o_Step_Up     = step_q[BTN_UP];
  assign o_Step_Dn     = step_q[BTN_DN];
  assign o_Step_Lt     = step_q[BTN_LT];
  assign o_Step_Rt     = step_q[BTN_RT];
  assign o_Start_Pulse = start_q;

endmodule

// File: tb/tb_frogg_input_ctrl.sv
// Bench for frogg_input_ctrl: two DUTs (repeat on / repeat off) share one stimulus,
// a history-based model is checked every cycle, directed phases pin literal timings.
module tb_frogg_input_ctrl;

  localparam int L  = 4;
  localparam int P  = 5;
  localparam int DA = 10;
  localparam int DB = 0;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] raw;

  logic [4:0] a_lvl, b_lvl;
  logic       a_up, a_dn, a_lt, a_rt, a_st;
  logic       b_up, b_dn, b_lt, b_rt, b_st;
  logic [3:0] a_stp, b_stp;

  assign a_stp = {a_rt, a_lt, a_dn, a_up};
  assign b_stp = {b_rt, b_lt, b_dn, b_up};

  frogg_input_ctrl #(
    .c_DEBOUNCE_LIMIT(L),
    .c_REPEAT_DELAY  (DA),
    .c_REPEAT_PERIOD (P)
  ) dut_a (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Enable     (en),
    .i_Btn_Raw    (raw),
    .o_Btn_Level  (a_lvl),
    .o_Step_Up    (a_up),
    .o_Step_Dn    (a_dn),
    .o_Step_Lt    (a_lt),
    .o_Step_Rt    (a_rt),
    .o_Start_Pulse(a_st)
  );

  frogg_input_ctrl #(
    .c_DEBOUNCE_LIMIT(L),
    .c_REPEAT_DELAY  (DB),
    .c_REPEAT_PERIOD (P)
  ) dut_b (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Enable     (en),
    .i_Btn_Raw    (raw),
    .o_Btn_Level  (b_lvl),
    .o_Step_Up    (b_up),
    .o_Step_Dn    (b_dn),
    .o_Step_Lt    (b_lt),
    .o_Step_Rt    (b_rt),
    .o_Start_Pulse(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Synced value seen at edge n is the raw value sampled at edge n-1.
  // The level flips at edge n when the last L synced samples all differ from it.
  // A step follows a level rise by one clock; repeats come at D, D+P, D+2P...
  // clocks after the first step while the level stays high and steps stay allowed.
  int         cyc = 0;
  bit         mvalid = 0;
  logic [4:0] synh [16];
  logic [4:0] lvlh [16];
  logic [4:0] s1m;
  bit         act [2][4];
  int         t0  [2][4];
  int         dcfg [2] = '{DA, DB};
  logic [4:0] exp_lvl;
  logic [3:0] exp_step [2];
  logic       exp_start;

  function automatic int ix(input int n);
    return n & 15;
  endfunction

  always @(posedge clk) begin
    logic [4:0] nl, lp, lpp;
    logic [3:0] allow;
    bit flip;
    int e;
    cyc++;
    if (rst) begin
      mvalid = 1;
      s1m    = '0;
      for (int k = 0; k < 16; k++) begin
        synh[k] = '0;
        lvlh[k] = '0;
      end
      for (int c = 0; c < 2; c++) begin
        for (int d = 0; d < 4; d++) act[c][d] = 0;
        exp_step[c] = '0;
      end
      exp_lvl   = '0;
      exp_start = 1'b0;
    end else begin
      lp  = lvlh[ix(cyc - 1)];
      lpp = lvlh[ix(cyc - 2)];
      for (int b = 0; b < 5; b++) begin
        flip = 1;
        for (int k = 1; k <= L; k++)
          if (synh[ix(cyc - k)][b] == lp[b]) flip = 0;
        nl[b] = flip ? ~lp[b] : lp[b];
      end
      synh[ix(cyc)] = s1m;
      s1m           = raw;
      lvlh[ix(cyc)] = nl;
      exp_lvl       = nl;

      allow[0] = en & ~(lp[0] & lp[1]);
      allow[1] = allow[0];
      allow[2] = en & ~(lp[2] & lp[3]);
      allow[3] = allow[2];
      for (int c = 0; c < 2; c++) begin
        for (int d = 0; d < 4; d++) begin
          exp_step[c][d] = 1'b0;
          if (!allow[d]) begin
            act[c][d] = 0;
          end else if (act[c][d]) begin
            if (!lp[d]) begin
              act[c][d] = 0;
            end else begin
              e = cyc - t0[c][d];
              if (e == dcfg[c] || (e > dcfg[c] && ((e - dcfg[c]) % P) == 0))
                exp_step[c][d] = 1'b1;
            end
          end else if (lp[d] && !lpp[d]) begin
            exp_step[c][d] = 1'b1;
            t0[c][d]       = cyc;
            act[c][d]      = (dcfg[c] != 0);
          end
        end
      end
      exp_start = lp[4] & ~lpp[4];
    end
  end

  // ---------------- compare + phase logging ----------------
  int base = 0;
  int a_cnt [4], b_cnt [4], a_first [4], b_first [4];
  int st_cnt, st_first, lvl_rise;
  int upq [$];

  always @(negedge clk) begin
    if (mvalid) begin
      chk("level_a", a_lvl, exp_lvl);
      chk("level_b", b_lvl, exp_lvl);
      chk("steps_a", a_stp, exp_step[0]);
      chk("steps_b", b_stp, exp_step[1]);
      chk("start_a", a_st, exp_start);
      chk("start_b", b_st, exp_start);
    end
    for (int d = 0; d < 4; d++) begin
      if (a_stp[d]) begin
        a_cnt[d]++;
        if (a_first[d] < 0) a_first[d] = cyc - base;
        if (d == 0) upq.push_back(cyc - base);
      end
      if (b_stp[d]) begin
        b_cnt[d]++;
        if (b_first[d] < 0) b_first[d] = cyc - base;
      end
    end
    if (a_st) begin
      st_cnt++;
      if (st_first < 0) st_first = cyc - base;
    end
    if (a_lvl[0] && lvl_rise < 0) lvl_rise = cyc - base;
  end

  // Drive and mark just after the falling edge, clear of both compare and model
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    base = cyc;
    for (int d = 0; d < 4; d++) begin
      a_cnt[d] = 0; b_cnt[d] = 0; a_first[d] = -1; b_first[d] = -1;
    end
    st_cnt = 0; st_first = -1; lvl_rise = -1;
    upq.delete();
  endtask

  int exp_up [6] = '{7, 17, 22, 27, 32, 37};

  initial begin
    rst = 1'b1; en = 1'b1; raw = '0;
    mark();
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_level", a_lvl, 0);
    chk("reset_steps", a_stp, 0);
    chk("reset_start", a_st, 0);

    // Up held: raw high for edges 1..35 so the level is low again before edge 42
    mark();
    raw[0] = 1'b1;
    tick(35);
    raw[0] = 1'b0;
    tick(20);
    chk("up_level_rise", lvl_rise, 6);
    chk("up_step_count", a_cnt[0], 6);
    for (int i = 0; i < 6; i++)
      chk("up_step_time", (upq.size() > i) ? upq[i] : -1, exp_up[i]);
    chk("norepeat_count", b_cnt[0], 1);
    chk("norepeat_first", b_first[0], 7);

    // Glitching Up never settles long enough
    mark();
    repeat (8) begin
      raw[0] = 1'b1; tick(3);
      raw[0] = 1'b0; tick(1);
    end
    tick(10);
    chk("glitch_level", lvl_rise, -1);
    chk("glitch_steps", a_cnt[0], 0);

    // Up+Dn together: blocked, and no replay once Dn is released
    mark();
    raw[1:0] = 2'b11;
    tick(30);
    chk("conflict_up", a_cnt[0], 0);
    chk("conflict_dn", a_cnt[1], 0);
    mark();
    raw[1] = 1'b0;
    tick(30);
    chk("unblock_up", a_cnt[0], 0);
    chk("unblock_dn", a_cnt[1], 0);
    raw[0] = 1'b0;
    tick(10);
    mark();
    raw[0] = 1'b1;
    tick(12);
    chk("repress_up", a_first[0], 7);
    raw[0] = 1'b0;
    tick(12);

    // Start held with steps disabled
    en = 1'b0;
    mark();
    raw[4] = 1'b1;
    tick(50);
    raw[4] = 1'b0;
    tick(10);
    chk("start_count", st_cnt, 1);
    chk("start_first", st_first, 7);
    en = 1'b1;
    tick(2);

    // Enable dropped right before the step due at 27
    mark();
    raw[2] = 1'b1;
    tick(26);
    chk("lt_before_drop", a_cnt[2], 3);
    en = 1'b0;
    mark();
    tick(20);
    chk("lt_disabled", a_cnt[2], 0);
    en = 1'b1;
    mark();
    tick(20);
    chk("lt_reenabled", a_cnt[2], 0);
    raw[2] = 1'b0;
    tick(10);
    mark();
    raw[2] = 1'b1;
    tick(10);
    chk("lt_repress", a_first[2], 7);
    raw[2] = 1'b0;
    tick(10);

    // Up and Rt together, then a one-clock reset mid-hold
    mark();
    raw[0] = 1'b1; raw[3] = 1'b1;
    tick(20);
    chk("ortho_up", a_first[0], 7);
    chk("ortho_rt", a_first[3], 7);
    rst = 1'b1;
    mark();
    tick(1);
    rst = 1'b0;
    chk("rst_level", a_lvl, 0);
    tick(20);
    chk("rst_rt_step", a_first[3], L + 4);
    chk("rst_up_step", a_first[0], L + 4);
    raw = '0;
    tick(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
